// File: rtl/dst_drain_pkg.sv
// Shared types and constants for the destination-buffer drain block.
package dst_drain_pkg;

    localparam int DST_DW = 32;  // one buffer word
    localparam int DST_AW = 13;  // {bank, 1'b0, pair[10:0]}
    localparam int PAIR_W = 11;  // pair index field of the read address
    localparam int CNT_W  = 12;  // pair counters, range 0..2048

    localparam logic [CNT_W-1:0] MAX_PAIRS = 12'd2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // A bank holds 2048 pairs; larger requests drain the whole bank once.
    function automatic logic [CNT_W-1:0] clamp_pairs(input logic [CNT_W-1:0] n);
        return (n > MAX_PAIRS) ? MAX_PAIRS : n;
    endfunction

endpackage

// File: rtl/dst_drain_fifo.sv
// Small synchronous FIFO with a combinational head; holds returned word pairs.
module dst_drain_fifo
    import dst_drain_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int FCNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [W-1:0]      wdata_i,
    output logic [W-1:0]      head_o,
    output logic [FCNT_W-1:0] count_o,
    output logic              empty_o
);

    logic [W-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d;
    logic              pop_ok;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);

    // Pointer and occupancy update; a simultaneous push and pop keeps the count.
    always_comb begin
        wr_d  = push_i ? bump(wr_q) : wr_q;
        rd_d  = pop_ok ? bump(rd_q) : rd_q;
        cnt_d = cnt_q;
        case ({push_i, pop_ok})
            2'b10:   cnt_d = cnt_q + FCNT_W'(1);
            2'b01:   cnt_d = cnt_q - FCNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state, cleared asynchronously so the output valid drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are only observed behind the occupancy count.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/dst_drain.sv
// Drains one bank of the accumulation buffer as a 2-word valid/ready stream.
module dst_drain
    import dst_drain_pkg::*;
#(
    parameter int DW    = DST_DW,
    parameter int AW    = DST_AW,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bank,
    input  logic [CNT_W-1:0]  npair,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              dst_v,
    output logic [AW-1:0]     dst_a,
    input  logic [DW-1:0]     dst_d0,
    input  logic [DW-1:0]     dst_d1,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [2*DW-1:0]   m_data,
    output logic              m_last
);

    localparam int FCW = $clog2(DEPTH + 1);
    localparam int CUW = FCW + 1;

    state_e           state_q, state_d;
    logic             bank_q, bank_d;
    logic [CNT_W-1:0] npair_q, npair_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             inflight_q;

    logic             pop, rd_en, credit_ok;
    logic [FCW-1:0]   fifo_cnt;
    logic             fifo_empty;
    logic [2*DW-1:0]  fifo_head;
    logic [CUW-1:0]   credit_use, credit_lim;
    logic [CNT_W-1:0] npair_clamped;

    assign pop           = m_valid & m_ready;
    assign npair_clamped = clamp_pairs(npair);

    // Every issued read owns a FIFO slot: (count + inflight - pop) < DEPTH.
    assign credit_use = {1'b0, fifo_cnt} + {{FCW{1'b0}}, inflight_q};
    assign credit_lim = CUW'(DEPTH) + {{FCW{1'b0}}, pop};
    assign credit_ok  = credit_use < credit_lim;

    // Next-state, read issue and counter updates.
    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        npair_d  = npair_q;
        issued_d = issued_q;
        acc_d    = acc_q;
        rd_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bank_d   = bank;
                    npair_d  = npair_clamped;
                    issued_d = '0;
                    acc_d    = '0;
                    state_d  = (npair_clamped == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                // hold gates the strobe in the same cycle so no read meets a buffer write
                rd_en = (issued_q < npair_q) && !hold && credit_ok;
                if (rd_en) issued_d = issued_q + CNT_W'(1);
                if (pop) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_q + CNT_W'(1) == npair_q) state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and control registers; reset abandons any drain without a done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bank_q     <= 1'b0;
            npair_q    <= '0;
            issued_q   <= '0;
            acc_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            npair_q    <= npair_d;
            issued_q   <= issued_d;
            acc_q      <= acc_d;
            inflight_q <= rd_en;
        end
    end

    // Returned pair is captured the cycle after its read strobe.
    dst_drain_fifo #(
        .W     (2 * DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .wdata_i ({dst_d1, dst_d0}),
        .head_o  (fifo_head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    assign dst_v   = rd_en;
    assign dst_a   = rd_en ? {bank_q, 1'b0, issued_q[PAIR_W-1:0]} : '0;
    assign m_valid = ~fifo_empty;
    assign m_data  = fifo_empty ? '0 : fifo_head;
    assign m_last  = m_valid && (state_q == RUN) && (acc_q == npair_q - CNT_W'(1));
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);

endmodule

// File: tb/tb_dst_drain.sv
// Randomized bench for dst_drain with a behavioural buffer/stream model.
module tb_dst_drain;

    logic        clk = 1'b0;
    logic        rst, start, bank, hold, m_ready;
    logic [11:0] npair;
    logic        busy, done, dst_v, m_valid, m_last;
    logic [12:0] dst_a;
    logic [31:0] dst_d0, dst_d1;
    logic [63:0] m_data;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] salt;

    dst_drain dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bank    (bank),
        .npair   (npair),
        .hold    (hold),
        .busy    (busy),
        .done    (done),
        .dst_v   (dst_v),
        .dst_a   (dst_a),
        .dst_d0  (dst_d0),
        .dst_d1  (dst_d1),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    // Buffer contents: word of pair p is p*2 (+1 for the odd word), scrambled by salt.
    function automatic logic [31:0] bufword(input logic [12:0] a, input logic odd);
        return salt ^ {20'd0, a[10:0], odd};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One drain: start at cycle 0, then act as buffer and sink every cycle.
    task automatic run_drain(input logic bk, input int n, input int rmode,
                             input int hold_lo, input int hold_hi,
                             input int restart_cyc, input int rst_beats, input bit contig);
        int          exp_n, cyc, issue, acc, first_v, last_v, first_mv, last_acc, post;
        bit          finished, pend, prev_stall, prev_last;
        logic [12:0] pend_a, ea;
        logic [63:0] prev_data;
        exp_n = (n > 2048) ? 2048 : n;
        cyc = 0; issue = 0; acc = 0;
        first_v = -1; last_v = -1; first_mv = -1; last_acc = -1; post = -1;
        finished = 0; pend = 0; prev_stall = 0; prev_last = 0;
        pend_a = '0; prev_data = '0;
        @(posedge clk); #1;
        forever begin
            start = (cyc == 0) || (cyc == restart_cyc);
            bank  = (cyc == restart_cyc) ? ~bk : bk;
            npair = (cyc == restart_cyc) ? 12'd1 : 12'(n);
            hold  = (cyc >= hold_lo) && (cyc <= hold_hi);
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (pend) begin
                dst_d0 = bufword(pend_a, 1'b0);
                dst_d1 = bufword(pend_a, 1'b1);
            end else begin
                dst_d0 = $urandom;
                dst_d1 = $urandom;
            end
            @(negedge clk);
            chk("busy", 64'(busy), 64'(cyc >= 1 && !finished));
            if (hold) chk("hold_gate", 64'(dst_v), 64'(0));
            if (dst_v) begin
                chk("dst_a", 64'(dst_a), 64'({bk, 1'b0, 11'(issue)}));
                chk("overissue", 64'(issue < exp_n), 64'(1));
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                issue++;
            end
            pend   = dst_v;
            pend_a = dst_a;
            if (m_valid && first_mv < 0) begin
                first_mv = cyc;
                chk("latency", 64'(cyc - first_v), 64'(2));
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'(1));
                chk("stall_data", m_data, prev_data);
                chk("stall_last", 64'(m_last), 64'(prev_last));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                ea = {bk, 1'b0, 11'(acc)};
                chk("m_data", m_data, {bufword(ea, 1'b1), bufword(ea, 1'b0)});
                chk("m_last", 64'(m_last), 64'(acc == exp_n - 1));
                acc++;
                last_acc = cyc;
            end
            chk("credit", 64'((issue - acc) <= 2), 64'(1));
            if (done) begin
                chk("done_once", 64'(finished), 64'(0));
                chk("done_time", 64'(cyc), 64'((exp_n == 0) ? 1 : last_acc + 1));
                chk("beats", 64'(acc), 64'(exp_n));
                chk("reads", 64'(issue), 64'(exp_n));
                if (contig && exp_n > 0) chk("contig", 64'(last_v - first_v), 64'(exp_n - 1));
                finished = 1;
                post = cyc + 1;
            end
            if (rst_beats >= 0 && acc == rst_beats) begin
                @(posedge clk); #1;
                start = 1'b0;
                rst = 1'b1;
                #1;
                chk("rst_outs", 64'({busy, done, dst_v, dst_a, m_valid, m_last}), 64'(0));
                chk("rst_data", m_data, 64'(0));
                @(posedge clk); #1;
                rst = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("rst_quiet", 64'({done, busy, m_valid, dst_v}), 64'(0));
                end
                break;
            end
            if (cyc == post) break;
            if (cyc > 20000) begin
                chk("timeout", 64'(0), 64'(1));
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        int hl;
        rst = 1'b1; start = 1'b0; bank = 1'b0; npair = '0; hold = 1'b0;
        m_ready = 1'b0; dst_d0 = '0; dst_d1 = '0; salt = '0;
        #2;
        chk("reset_outs", 64'({busy, done, dst_v, dst_a, m_valid, m_last}), 64'(0));
        chk("reset_data", m_data, 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_drain(1'b0, 4, 0, -1, -2, -1, -1, 1);     // basic
        run_drain(1'b1, 3, 0, -1, -2, -1, -1, 1);     // bank 1, plain data
        salt = $urandom;
        run_drain(1'b0, 8, 1, -1, -2, -1, -1, 0);     // backpressure 1,0,0
        run_drain(1'b1, 6, 0, 2, 5, -1, -1, 0);       // hold cycles 2-5
        run_drain(1'b0, 0, 0, -1, -2, -1, -1, 0);     // no pairs
        run_drain(1'b1, 2048, 0, -1, -2, -1, -1, 1);  // full bank
        run_drain(1'b0, 3000, 2, -1, -2, -1, -1, 0);  // clamped to 2048
        run_drain(1'b1, 12, 1, -1, -2, 3, -1, 0);     // start ignored while busy
        run_drain(1'b0, 10, 0, -1, -2, -1, 3, 0);     // reset after 3 beats
        run_drain(1'b0, 2, 0, -1, -2, -1, -1, 1);     // clean drain after reset
        for (int r = 0; r < 12; r++) begin
            salt = $urandom;
            hl   = $urandom_range(0, 10);
            run_drain(1'($urandom_range(0, 1)), $urandom_range(1, 40), 2,
                      hl, hl + $urandom_range(0, 6), -1, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
